// File: rtl/matvec_pkg.sv
// Shared types and helpers for the sequential matrix-vector multiplier.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width that holds a COLS-term sum of DW x DW products with no wrap.
    function automatic int acc_width(input int dw, input int cols);
        return 2 * dw + $clog2(cols) + 1;
    endfunction

endpackage

// File: rtl/matvec_if.sv
// Operand/result handshake bundle between the source/consumer (master) and the multiplier (slave).
interface matvec_if #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int DW   = 8,
    parameter int AW   = matvec_pkg::acc_width(DW, COLS)
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_signed;
    logic [ROWS*COLS*DW-1:0]   mat;
    logic [COLS*DW-1:0]        vec;
    logic                      out_valid;
    logic                      out_ready;
    logic [ROWS*AW-1:0]        result;

    modport master (
        output in_valid, in_signed, mat, vec, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_signed, mat, vec, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/matvec_seq_mac_unit.sv
// Shared multiply-accumulate: registered accumulator plus combinational acc + a*b.
module mac_unit #(
    parameter int DW = 8,
    parameter int AW = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          last,
    input  logic          is_signed,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] sum
);
    logic signed [2*DW-1:0] prod_s;
    logic        [2*DW-1:0] prod_u;
    logic        [AW-1:0]   prod_ext;
    logic        [AW-1:0]   acc_reg;

    assign prod_s   = $signed(a) * $signed(b);
    assign prod_u   = a * b;
    assign prod_ext = is_signed ? {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s}
                                : {{(AW-2*DW){1'b0}}, prod_u};
    assign sum      = acc_reg + prod_ext;

    // The last term of a row goes straight out through sum, so the accumulator restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= last ? '0 : sum;
        end
    end
endmodule

// File: rtl/matvec_seq.sv
// Sequential y = M * v using one shared MAC, one product per cycle, valid/ready on both sides.
module matvec_seq
    import matvec_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int DW   = 8,
    parameter int AW   = acc_width(DW, COLS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    output logic        busy,
    matvec_if.slave     bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t                  state_reg, state_next;
    logic [RW-1:0]           row_reg;
    logic [CW-1:0]           col_reg;
    logic [ROWS*COLS*DW-1:0] mat_reg;
    logic [COLS*DW-1:0]      vec_reg;
    logic                    signed_reg;
    logic [AW-1:0]           result_reg [ROWS];

    logic          capture, step, last_col, last_row;
    logic [DW-1:0] m_elem, v_elem;
    logic [AW-1:0] mac_sum;

    assign capture  = (state_reg == IDLE) && bus.in_valid;
    assign step     = (state_reg == BUSY) && !abort;
    assign last_col = (col_reg == CW'(COLS - 1));
    assign last_row = (row_reg == RW'(ROWS - 1));

    assign m_elem = mat_reg[(int'(row_reg) * COLS + int'(col_reg)) * DW +: DW];
    assign v_elem = vec_reg[int'(col_reg) * DW +: DW];

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign busy          = (state_reg == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = BUSY;
            BUSY: begin
                if (abort)                     state_next = IDLE;
                else if (last_row && last_col) state_next = DONE;
            end
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg    <= '0;
            col_reg    <= '0;
            mat_reg    <= '0;
            vec_reg    <= '0;
            signed_reg <= 1'b0;
        end else if (capture) begin
            row_reg    <= '0;
            col_reg    <= '0;
            mat_reg    <= bus.mat;
            vec_reg    <= bus.vec;
            signed_reg <= bus.in_signed;
        end else if (state_reg == BUSY && abort) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (step) begin
            if (last_col) begin
                col_reg <= '0;
                row_reg <= last_row ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    mac_unit #(.DW(DW), .AW(AW)) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (capture || (state_reg == BUSY && abort)),
        .en        (step),
        .last      (last_col),
        .is_signed (signed_reg),
        .a         (m_elem),
        .b         (v_elem),
        .sum       (mac_sum)
    );

    // Each row register loads on the final column of its own row only.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    result_reg[gi] <= '0;
                end else if (step && last_col && row_reg == RW'(gi)) begin
                    result_reg[gi] <= mac_sum;
                end
            end
            assign bus.result[gi*AW +: AW] = result_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_matvec_seq.sv
// Directed self-checking bench for matvec_seq: default 3x3x8 plus 1x1x8 and 4x5x12 instances.
module tb_matvec_seq;
    import matvec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic abort0, abort1, abort2;
    logic busy0, busy1, busy2;

    matvec_if #(.ROWS(3), .COLS(3), .DW(8),  .AW(19)) i0 ();
    matvec_if #(.ROWS(1), .COLS(1), .DW(8),  .AW(17)) i1 ();
    matvec_if #(.ROWS(4), .COLS(5), .DW(12), .AW(28)) i2 ();

    matvec_seq #(.ROWS(3), .COLS(3), .DW(8), .AW(19)) u0 (
        .clk(clk), .rst_n(rst_n), .abort(abort0), .busy(busy0), .bus(i0.slave));
    matvec_seq #(.ROWS(1), .COLS(1), .DW(8), .AW(17)) u1 (
        .clk(clk), .rst_n(rst_n), .abort(abort1), .busy(busy1), .bus(i1.slave));
    matvec_seq #(.ROWS(4), .COLS(5), .DW(12), .AW(28)) u2 (
        .clk(clk), .rst_n(rst_n), .abort(abort2), .busy(busy2), .bus(i2.slave));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [63:0] y0(input int r, input bit sg);
        logic signed [18:0] s;
        logic        [18:0] u;
        s = i0.result[r*19 +: 19];
        u = i0.result[r*19 +: 19];
        if (sg) return 64'(s);
        return 64'(u);
    endfunction

    task automatic start0(input logic [71:0] m, input logic [23:0] v, input logic sg);
        int n;
        n = 0;
        while (!i0.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("start0_in_ready", 64'(i0.in_ready), 64'd1);
        i0.mat       = m;
        i0.vec       = v;
        i0.in_signed = sg;
        i0.in_valid  = 1'b1;
        tick();
        i0.in_valid  = 1'b0;
    endtask

    task automatic wait_out0(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!i0.out_valid && lat < 40);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [71:0] m_id;
        logic [18:0] snap [3];
        int m2 [4][5];
        int v2 [5];
        longint e2;
        logic signed [27:0] s2;
        logic signed [16:0] s1;

        rst_n = 1'b0;
        abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
        i0.in_valid = 1'b0; i0.in_signed = 1'b0; i0.mat = '0; i0.vec = '0; i0.out_ready = 1'b1;
        i1.in_valid = 1'b0; i1.in_signed = 1'b0; i1.mat = '0; i1.vec = '0; i1.out_ready = 1'b1;
        i2.in_valid = 1'b0; i2.in_signed = 1'b0; i2.mat = '0; i2.vec = '0; i2.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(i0.in_ready), 64'd1);
        check("rst_out_valid", 64'(i0.out_valid), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_result", 64'(i0.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: unsigned all-ones, latency
        start0({9{8'hFF}}, {3{8'hFF}}, 1'b0);
        check("t1_busy", 64'(busy0), 64'd1);
        check("t1_in_ready_busy", 64'(i0.in_ready), 64'd0);
        wait_out0(lat);
        check("t1_latency", 64'(lat), 64'd9);
        for (int r = 0; r < 3; r++) check("t1_y", y0(r, 0), 64'd195075);
        tick();
        check("t1_back_idle_valid", 64'(i0.out_valid), 64'd0);
        check("t1_back_idle_ready", 64'(i0.in_ready), 64'd1);

        // 2: signed corner and mixed-sign row
        start0({9{8'h80}}, {3{8'h80}}, 1'b1);
        wait_out0(lat);
        for (int r = 0; r < 3; r++) check("t2_min_sq", y0(r, 1), 64'd49152);
        start0({48'h0, 8'hFD, 8'h02, 8'hFF}, {8'd6, 8'd5, 8'd4}, 1'b1);
        wait_out0(lat);
        check("t2_y0", y0(0, 1), -64'sd12);
        check("t2_y1", y0(1, 1), 64'd0);

        // 3: identity, unsigned then signed
        m_id = '0;
        for (int r = 0; r < 3; r++) m_id[(r*3+r)*8 +: 8] = 8'd1;
        start0(m_id, {8'd3, 8'd200, 8'd7}, 1'b0);
        wait_out0(lat);
        check("t3u_y0", y0(0, 0), 64'd7);
        check("t3u_y1", y0(1, 0), 64'd200);
        check("t3u_y2", y0(2, 0), 64'd3);
        start0(m_id, {8'd3, 8'd200, 8'd7}, 1'b1);
        wait_out0(lat);
        check("t3s_y0", y0(0, 1), 64'd7);
        check("t3s_y1", y0(1, 1), -64'sd56);
        check("t3s_y2", y0(2, 1), 64'd3);

        // 4: consumer back-pressure
        tick();
        i0.out_ready = 1'b0;
        start0(m_id, {8'd9, 8'd8, 8'd5}, 1'b0);
        wait_out0(lat);
        check("t4_latency", 64'(lat), 64'd9);
        for (int r = 0; r < 3; r++) snap[r] = i0.result[r*19 +: 19];
        check("t4_y1", 64'(snap[1]), 64'd8);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_hold_valid", 64'(i0.out_valid), 64'd1);
            check("t4_hold_in_ready", 64'(i0.in_ready), 64'd0);
            check("t4_hold_result", 64'(i0.result), 64'({snap[2], snap[1], snap[0]}));
        end
        i0.out_ready = 1'b1;
        tick();
        check("t4_release_ready", 64'(i0.in_ready), 64'd1);
        check("t4_release_valid", 64'(i0.out_valid), 64'd0);

        // 5: abort during the 4th busy cycle, then a clean run
        start0({9{8'hFF}}, {3{8'hFF}}, 1'b0);
        tick(); tick(); tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        check("t5_abort_ready", 64'(i0.in_ready), 64'd1);
        check("t5_abort_busy", 64'(busy0), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            seen = seen | i0.out_valid;
            tick();
        end
        check("t5_no_out_valid", 64'(seen), 64'd0);
        start0({48'h0, 8'hFD, 8'h02, 8'hFF}, {8'd6, 8'd5, 8'd4}, 1'b1);
        wait_out0(lat);
        check("t5_latency", 64'(lat), 64'd9);
        check("t5_y0", y0(0, 1), -64'sd12);
        tick();

        // 6: asynchronous reset mid-busy
        start0({9{8'h11}}, {3{8'h22}}, 1'b0);
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 64'(i0.in_ready), 64'd1);
        check("t6_rst_busy", 64'(busy0), 64'd0);
        check("t6_rst_valid", 64'(i0.out_valid), 64'd0);
        check("t6_rst_result", 64'(i0.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Sweep: 1x1, one row completes per edge
        i1.mat = 8'hF9; i1.vec = 8'd9; i1.in_signed = 1'b1; i1.in_valid = 1'b1;
        tick();
        i1.in_valid = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!i1.out_valid && lat < 10);
        check("s1_latency", 64'(lat), 64'd1);
        s1 = i1.result;
        check("s1_signed", 64'(s1), -64'sd63);
        tick();
        i1.mat = 8'hFF; i1.vec = 8'hFF; i1.in_signed = 1'b0; i1.in_valid = 1'b1;
        tick();
        i1.in_valid = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!i1.out_valid && lat < 10);
        check("s1_unsigned", 64'(i1.result), 64'd65025);

        // Sweep: 4x5x12 against a bench-side model, signed then unsigned
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                m2[r][c] = r*37 + c*113 - 300;
                i2.mat[(r*5+c)*12 +: 12] = 12'(m2[r][c]);
            end
        for (int c = 0; c < 5; c++) begin
            v2[c] = c*500 - 1000;
            i2.vec[c*12 +: 12] = 12'(v2[c]);
        end
        i2.in_signed = 1'b1; i2.in_valid = 1'b1;
        tick();
        i2.in_valid = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!i2.out_valid && lat < 60);
        check("s2_latency", 64'(lat), 64'd20);
        for (int r = 0; r < 4; r++) begin
            e2 = 0;
            for (int c = 0; c < 5; c++) e2 += longint'(m2[r][c]) * longint'(v2[c]);
            s2 = i2.result[r*28 +: 28];
            check("s2_signed_y", 64'(s2), 64'(e2));
        end
        tick();
        i2.mat = {20{12'hFFF}}; i2.vec = {5{12'hFFF}}; i2.in_signed = 1'b0; i2.in_valid = 1'b1;
        tick();
        i2.in_valid = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!i2.out_valid && lat < 60);
        e2 = 5 * 64'd4095 * 64'd4095;
        for (int r = 0; r < 4; r++) check("s2_unsigned_y", 64'(i2.result[r*28 +: 28]), 64'(e2));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
